// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with stall/flush handling
// and saturating hold/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W      = 103,
  parameter int unsigned          STAGE          = 4,
  parameter int unsigned          STALL_W        = 6,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE      = '0,
  parameter bit                   ZERO_ON_BUBBLE = 1'b1,
  parameter int unsigned          CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  input  logic                 clr_cnt,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // Masks select the stall bits; the last stage has no downstream bit.
  localparam logic [STALL_W-1:0] UP_MASK =
    STALL_W'(1) << STAGE;
  localparam logic [STALL_W-1:0] DN_MASK =
    (STAGE + 1 < STALL_W) ? (STALL_W'(1) << (STAGE + 1))
                          : '0;

  logic up_stop;
  logic dn_stop;
  logic do_flush;
  logic do_bub;
  logic do_hold;
  logic do_adv;

  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic                 val_q, val_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]     bub_q, bub_d;

  assign up_stop  = |(stall & UP_MASK);
  assign dn_stop  = |(stall & DN_MASK);
  assign do_flush = flush;
  assign do_bub   = !flush && up_stop && !dn_stop;
  assign do_hold  = !flush && up_stop && dn_stop;
  assign do_adv   = !flush && !up_stop;

  always_comb begin
    pay_d = pay_q;
    val_d = val_q;
    unique case (1'b1)
      do_flush: begin
        pay_d = NOP_VALUE;
        val_d = 1'b0;
      end
      do_bub: begin
        if (ZERO_ON_BUBBLE) pay_d = NOP_VALUE;
        val_d = 1'b0;
      end
      do_hold: begin
        pay_d = pay_q;
        val_d = val_q;
      end
      do_adv: begin
        pay_d = in_payload;
        val_d = in_valid;
      end
      default: begin
        pay_d = pay_q;
        val_d = val_q;
      end
    endcase
  end

  // Clear wins over increment; counters stick at all-ones.
  always_comb begin
    hold_d = hold_q;
    bub_d  = bub_q;
    if (clr_cnt) begin
      hold_d = '0;
      bub_d  = '0;
    end else begin
      if (do_hold && !(&hold_q)) hold_d = hold_q + CNT_W'(1);
      if (do_bub && !(&bub_q))   bub_d  = bub_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q  <= NOP_VALUE;
      val_q  <= 1'b0;
      hold_q <= '0;
      bub_q  <= '0;
    end else begin
      pay_q  <= pay_d;
      val_q  <= val_d;
      hold_q <= hold_d;
      bub_q  <= bub_d;
    end
  end

  assign out_payload = pay_q;
  assign out_valid   = val_q;
  assign hold_cnt    = hold_q;
  assign bubble_cnt  = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three parameterisations share one stimulus
// stream; a reference model feeds a scoreboard queue.
module tb_pipe_stage_reg;

  localparam int W = 103;
  localparam logic [W-1:0] NOP_E = 103'h12_3456_789A_BCDE_F012_3456_789A;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic [W-1:0] in_payload;
  logic         in_valid;
  logic         clr_cnt;

  logic [W-1:0] d_pay, l_pay, e_pay;
  logic         d_val, l_val, e_val;
  logic [15:0]  d_hold, d_bub, e_hold, e_bub;
  logic [3:0]   l_hold, l_bub;

  always #5 clk = ~clk;

  pipe_stage_reg u_dflt (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .out_payload(d_pay), .out_valid(d_val),
    .hold_cnt(d_hold), .bubble_cnt(d_bub)
  );

  pipe_stage_reg #(.ZERO_ON_BUBBLE(1'b0), .CNT_W(4)) u_lt (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .out_payload(l_pay), .out_valid(l_val),
    .hold_cnt(l_hold), .bubble_cnt(l_bub)
  );

  pipe_stage_reg #(.STAGE(5), .NOP_VALUE(NOP_E)) u_edge (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .out_payload(e_pay), .out_valid(e_val),
    .hold_cnt(e_hold), .bubble_cnt(e_bub)
  );

  typedef struct {
    logic [W-1:0] pay;
    logic         val;
    int           hold;
    int           bub;
  } exp_t;

  exp_t exp_q[$];

  int           m_stage [3] = '{4, 4, 5};
  bit           m_zob   [3] = '{1'b1, 1'b0, 1'b1};
  int           m_max   [3] = '{65535, 15, 65535};
  logic [W-1:0] m_nop   [3];
  exp_t         m       [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [5:0] st, input logic fl,
                       input logic [W-1:0] p, input logic v,
                       input logic cc, input logic r);
    for (int i = 0; i < 3; i++) begin
      logic up, dn;
      bit bub_ev, hold_ev;
      up = st[m_stage[i]];
      dn = (m_stage[i] < 5) ? st[m_stage[i] + 1] : 1'b0;
      bub_ev = 0;
      hold_ev = 0;
      if (r) begin
        m[i].pay = m_nop[i];
        m[i].val = 1'b0;
        m[i].hold = 0;
        m[i].bub = 0;
      end else begin
        if (fl) begin
          m[i].pay = m_nop[i];
          m[i].val = 1'b0;
        end else if (up && !dn) begin
          m[i].val = 1'b0;
          if (m_zob[i]) m[i].pay = m_nop[i];
          bub_ev = 1;
        end else if (up && dn) begin
          hold_ev = 1;
        end else begin
          m[i].pay = p;
          m[i].val = v;
        end
        if (cc) begin
          m[i].hold = 0;
          m[i].bub = 0;
        end else begin
          if (hold_ev && m[i].hold < m_max[i]) m[i].hold++;
          if (bub_ev && m[i].bub < m_max[i]) m[i].bub++;
        end
      end
      exp_q.push_back(m[i]);
    end
  endtask

  task automatic step(input logic [5:0] st, input logic fl,
                      input logic [W-1:0] p, input logic v,
                      input logic cc, input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    stall = st;
    flush = fl;
    in_payload = p;
    in_valid = v;
    clr_cnt = cc;
    model(st, fl, p, v, cc, r);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("dflt_pay", d_pay, e.pay);
    chk("dflt_val", W'(d_val), W'(e.val));
    chk("dflt_hold", W'(d_hold), W'(e.hold));
    chk("dflt_bub", W'(d_bub), W'(e.bub));
    e = exp_q.pop_front();
    chk("lt_pay", l_pay, e.pay);
    chk("lt_val", W'(l_val), W'(e.val));
    chk("lt_hold", W'(l_hold), W'(e.hold));
    chk("lt_bub", W'(l_bub), W'(e.bub));
    e = exp_q.pop_front();
    chk("edge_pay", e_pay, e.pay);
    chk("edge_val", W'(e_val), W'(e.val));
    chk("edge_hold", W'(e_hold), W'(e.hold));
    chk("edge_bub", W'(e_bub), W'(e.bub));
  endtask

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] pa, pb, pc, pd, pe, pf, p5a;
    m_nop[0] = '0;
    m_nop[1] = '0;
    m_nop[2] = NOP_E;
    for (int i = 0; i < 3; i++) begin
      m[i].pay = 'x;
      m[i].val = 1'bx;
      m[i].hold = 0;
      m[i].bub = 0;
    end
    rst = 1'b1;
    stall = '0;
    flush = 1'b0;
    in_payload = '0;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    pa = rnd(); pb = rnd(); pc = rnd();
    pd = rnd(); pe = rnd(); pf = rnd();
    p5a = {13{8'h5A}};

    // reset with live payload at the input
    step(6'b000000, 0, p5a, 1, 0, 1);
    step(6'b000000, 0, p5a, 1, 0, 1);
    chk("rst_pay", d_pay, '0);
    chk("rst_edge_pay", e_pay, NOP_E);

    step(6'b000000, 0, p5a, 1, 0, 0);
    chk("rel_latency", d_pay, p5a);

    step(6'b000000, 0, pa, 1, 0, 0);
    step(6'b000000, 0, pb, 1, 0, 0);
    step(6'b000000, 0, pc, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      step(6'b111111, 0, rnd(), 1, 0, 0);
    chk("hold_pay", d_pay, pc);
    chk("hold_cnt4", W'(d_hold), W'(4));
    chk("hold_nobub", W'(d_bub), '0);

    step(6'b000000, 0, pd, 1, 0, 0);
    step(6'b011111, 0, rnd(), 1, 0, 0);
    chk("bub_zero_pay", d_pay, '0);
    chk("bub_keep_pay", l_pay, pd);
    chk("bub_keep_val", W'(l_val), '0);
    chk("bub_cnt1", W'(d_bub), W'(1));

    // flush beats bubble and leaves counters alone
    step(6'b011111, 1, rnd(), 1, 0, 0);
    chk("flush_bub", W'(d_bub), W'(1));
    chk("flush_lt_pay", l_pay, '0);
    step(6'b000000, 0, pe, 1, 0, 0);
    chk("flush_next", d_pay, pe);

    step(6'b100000, 0, rnd(), 1, 0, 0);
    chk("edge_bub_val", W'(e_val), '0);
    step(6'b100000, 0, rnd(), 1, 0, 0);
    step(6'b000000, 0, rnd(), 0, 0, 0);
    step(6'b110000, 0, rnd(), 1, 0, 0);

    // reset during stall and flush
    step(6'b111111, 1, rnd(), 1, 0, 1);
    chk("rst_mid_hold", W'(d_hold), '0);

    step(6'b000000, 0, pf, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      step(6'b111111, 0, rnd(), 1, 0, 0);
    chk("sat_lt_hold", W'(l_hold), W'(15));
    chk("sat_dflt_hold", W'(d_hold), W'(20));
    step(6'b111111, 0, rnd(), 1, 1, 0);
    chk("clr_hold", W'(l_hold), '0);
    chk("clr_pay", l_pay, pf);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] s;
      s = 6'($urandom);
      step(s, ($urandom_range(0, 7) == 0), rnd(), 1'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
